johnson_seq_ctrl: RTL and testbench

Sequencing controller for the team's Johnson counter datapath. On a start command it advances an internal WIDTH-stage Johnson register by a programmed number of steps, forward or reverse, with pause and abort control. It provides a busy/done handshake, and decodes the current code into a phase index and a one-hot phase vector for downstream multi-phase enables. It sits between a command master (CPU register block or test FSM) and the logic that consumes the phase enables.

---
 rtl/johnson_pkg.sv | 19 +
 rtl/johnson_decode.sv | 45 ++++
 rtl/johnson_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared encodings for the Johnson sequencing controller and its phase consumers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t  - controller FSM encoding (IDLE / RUN / HOLD)
//   DIR_FWD, DIR_REV - step direction constants
package johnson_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/johnson_decode.sv
// Maps a WIDTH-stage Johnson code to its ring position and a one-hot phase vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows count continuously.
//
// Ports:
//   count     in   WIDTH            Johnson code
//   phase_idx out  $clog2(2*WIDTH)  ring position 0..2*WIDTH-1
//   phase     out  2*WIDTH          one-hot of phase_idx
module johnson_decode #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]             count,
    output logic [$clog2(2*WIDTH)-1:0]   phase_idx,
    output logic [2*WIDTH-1:0]           phase
);

    localparam int IDX_W = $clog2(2*WIDTH);

    // 2*WIDTH may equal 2**IDX_W, in which case this truncates to zero; the
    // modular subtraction below still yields 2*WIDTH - popcount.
    localparam logic [IDX_W-1:0]   RING = IDX_W'(2*WIDTH);
    localparam logic [2*WIDTH-1:0] ONE  = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + {{(IDX_W-1){1'b0}}, count[i]};
        end
    end

    // First half of the ring fills from the MSB down (MSB set, or all-zero);
    // second half drains from the MSB, so its position counts back from 2*WIDTH.
    always_comb begin
        if (count[WIDTH-1] || (count == '0)) begin
            phase_idx = pop;
        end else begin
            phase_idx = RING - pop;
        end
    end

    assign phase = ONE << phase_idx;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Steps a Johnson register a commanded number of times, fwd/rev, with hold/abort.
// Latency: start accepted at E0, step k lands at E0+k, done pulses with final step.
// Backpressure: start is only taken in IDLE; starts while busy are dropped, not queued.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   start, steps, dir      command strobe with step count and direction
//   hold, abort            pause / cancel of the running command
//   clr                    zero the Johnson register while idle
//   busy, done             command in progress / one-cycle completion pulse
//   count                  Johnson register
//   phase_idx, phase       decoded ring position and its one-hot
module johnson_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CNT_W-1:0]             steps,
    input  logic                         dir,
    input  logic                         hold,
    input  logic                         abort,
    input  logic                         clr,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH-1:0]             count,
    output logic [$clog2(2*WIDTH)-1:0]   phase_idx,
    output logic [2*WIDTH-1:0]           phase
);

    import johnson_pkg::*;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rem_q,   rem_d;
    logic               dir_q,   dir_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               done_q,  done_d;

    logic [WIDTH-1:0]   count_fwd;
    logic [WIDTH-1:0]   count_rev;

    // Reverse is the exact inverse of forward, so a rev step undoes a fwd step.
    assign count_fwd = {~count_q[0], count_q[WIDTH-1:1]};
    assign count_rev = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            dir_q   <= DIR_FWD;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        count_d = count_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // start outranks clr; a zero-step command completes immediately.
                if (start) begin
                    if (steps != '0) begin
                        rem_d   = steps;
                        dir_d   = dir;
                        state_d = S_RUN;
                    end else begin
                        done_d  = 1'b1;
                    end
                end else if (clr) begin
                    count_d = '0;
                end
            end

            S_RUN: begin
                if (abort) begin
                    rem_d   = '0;
                    state_d = S_IDLE;
                end else if (hold) begin
                    state_d = S_HOLD;
                end else begin
                    count_d = (dir_q == DIR_REV) ? count_rev : count_fwd;
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                // Release returns to RUN without stepping: one bubble edge.
                if (abort) begin
                    rem_d   = '0;
                    state_d = S_IDLE;
                end else if (!hold) begin
                    state_d = S_RUN;
                end
            end

            default: begin
                rem_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy  = (state_q == S_RUN) || (state_q == S_HOLD);
    assign done  = done_q;
    assign count = count_q;

    johnson_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .count     (count_q),
        .phase_idx (phase_idx),
        .phase     (phase)
    );

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl: directed scenarios plus a randomized
// run compared each cycle against a ring-position reference model.
module tb_johnson_seq_ctrl;

    localparam int W   = 4;
    localparam int CW  = 8;
    localparam int NPH = 2 * W;

    logic          clk = 1'b0;
    logic          reset, start, dir, hold, abort, clr;
    logic [CW-1:0] steps;
    logic          busy, done;
    logic [W-1:0]  count;
    logic [2:0]    phase_idx;
    logic [7:0]    phase;

    int errors = 0;
    int checks = 0;

    // Reference model: position on the ring rather than the code itself.
    int m_pos    = 0;
    int m_rem    = 0;
    bit m_busy   = 0;
    bit m_paused = 0;
    bit m_done   = 0;
    bit m_dir    = 0;

    johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .steps     (steps),
        .dir       (dir),
        .hold      (hold),
        .abort     (abort),
        .clr       (clr),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .phase_idx (phase_idx),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    // Ring position p: first W positions fill ones from the MSB, the rest
    // keep (2W - p) ones at the LSB end.
    function automatic logic [W-1:0] code_of(int p);
        logic [W-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            if (p <= W) c[i] = (i >= W - p);
            else        c[i] = (i < NPH - p);
        end
        return c;
    endfunction

    task automatic model_edge();
        bit nd;
        nd = 1'b0;
        if (reset) begin
            m_pos = 0; m_rem = 0; m_busy = 0; m_paused = 0; m_done = 0;
        end else begin
            if (!m_busy) begin
                if (start) begin
                    if (steps != 0) begin
                        m_rem = steps; m_dir = dir; m_busy = 1; m_paused = 0;
                    end else begin
                        nd = 1'b1;
                    end
                end else if (clr) begin
                    m_pos = 0;
                end
            end else if (abort) begin
                m_busy = 0; m_rem = 0;
            end else if (m_paused) begin
                if (!hold) m_paused = 0;
            end else if (hold) begin
                m_paused = 1;
            end else begin
                m_pos = m_dir ? (m_pos + NPH - 1) % NPH : (m_pos + 1) % NPH;
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_busy = 0; nd = 1'b1;
                end
            end
            m_done = nd;
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; dir = 0; hold = 0; abort = 0; clr = 0; steps = '0;
    endtask

    task automatic do_clr();
        clr = 1; clk_step(); clr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; clk_step(); clk_step(); reset = 0;
        checks++; if (count !== 4'b0000) begin errors++; $display("FAIL reset_count got %b want 0000", count); end
        checks++; if (phase !== 8'b00000001) begin errors++; $display("FAIL reset_phase got %b want 00000001", phase); end
        checks++; if (phase_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", phase_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    endtask

    task automatic test_fwd3();
        logic [3:0] exp_c [3];
        int busy_n;
        exp_c[0] = 4'b1000; exp_c[1] = 4'b1100; exp_c[2] = 4'b1110;
        do_clr();
        start = 1; steps = 3; dir = 0; clk_step(); start = 0; steps = 0;
        checks++; if (busy !== 1'b1 || count !== 4'b0000) begin errors++; $display("FAIL fwd3_accept busy=%b count=%b want busy=1 count=0000", busy, count); end
        busy_n = busy ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            clk_step();
            checks++; if (count !== exp_c[k]) begin errors++; $display("FAIL fwd3_step%0d got %b want %b", k + 1, count, exp_c[k]); end
            if (busy) busy_n++;
        end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fwd3_done done=%b busy=%b want done=1 busy=0", done, busy); end
        checks++; if (phase_idx !== 3'd3) begin errors++; $display("FAIL fwd3_idx got %0d want 3", phase_idx); end
        checks++; if (busy_n != 3) begin errors++; $display("FAIL fwd3_busy_len got %0d want 3", busy_n); end
        clk_step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fwd3_done_pulse got %b want 0", done); end
    endtask

    task automatic test_wrap_rev();
        int n;
        bit seen;
        do_clr();
        start = 1; steps = 10; dir = 0; clk_step(); start = 0;
        seen = 0; n = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            clk_step(); n++;
            if (done) seen = 1;
        end
        checks++; if (!seen || n != 10) begin errors++; $display("FAIL wrap_latency seen=%b edges=%0d want 10", seen, n); end
        checks++; if (count !== 4'b1100 || phase_idx !== 3'd2) begin errors++; $display("FAIL wrap_final count=%b idx=%0d want 1100/2", count, phase_idx); end
        start = 1; steps = 1; dir = 1; clk_step(); start = 0;
        clk_step();
        checks++; if (done !== 1'b1 || count !== 4'b1000 || phase_idx !== 3'd1) begin errors++; $display("FAIL rev1 done=%b count=%b idx=%0d want 1/1000/1", done, count, phase_idx); end
    endtask

    task automatic test_hold();
        int e;
        bit seen;
        do_clr();
        start = 1; steps = 4; dir = 0; clk_step(); start = 0;
        clk_step(); clk_step();
        hold = 1;
        for (int k = 0; k < 2; k++) begin
            clk_step();
            checks++; if (count !== 4'b1100 || busy !== 1'b1) begin errors++; $display("FAIL hold_freeze%0d count=%b busy=%b want 1100/1", k, count, busy); end
        end
        hold = 0;
        e = 4; seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            clk_step(); e++;
            if (e == 5) begin
                checks++; if (count !== 4'b1100) begin errors++; $display("FAIL hold_bubble got %b want 1100", count); end
            end
            if (done) seen = 1;
        end
        checks++; if (!seen || e != 7) begin errors++; $display("FAIL hold_latency seen=%b edge=E0+%0d want E0+7", seen, e); end
        checks++; if (count !== 4'b1111) begin errors++; $display("FAIL hold_final got %b want 1111", count); end
    endtask

    task automatic test_abort();
        do_clr();
        start = 1; steps = 6; dir = 0; clk_step();
        // keep start high with a different command while running
        steps = 1; dir = 1; clk_step();
        clk_step();
        checks++; if (done !== 1'b0 || busy !== 1'b1 || count !== 4'b1100) begin errors++; $display("FAIL abort_ignore_start done=%b busy=%b count=%b want 0/1/1100", done, busy, count); end
        abort = 1; steps = 2; clk_step(); abort = 0; start = 0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || count !== 4'b1100) begin errors++; $display("FAIL abort_stop busy=%b done=%b count=%b want 0/0/1100", busy, done, count); end
        clk_step();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || count !== 4'b1100) begin errors++; $display("FAIL abort_after busy=%b done=%b count=%b want 0/0/1100", busy, done, count); end
    endtask

    task automatic test_edge_cmds();
        bit seen;
        int n;
        start = 1; steps = 0; clk_step(); start = 0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || count !== 4'b1100) begin errors++; $display("FAIL zero_steps done=%b busy=%b count=%b want 1/0/1100", done, busy, count); end
        clk_step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_steps_after done=%b busy=%b want 0/0", done, busy); end

        do_clr();
        start = 1; steps = 5; dir = 0; clk_step(); start = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin clk_step(); if (done) seen = 1; end
        checks++; if (!seen || count !== 4'b0111 || phase_idx !== 3'd5) begin errors++; $display("FAIL clr_setup seen=%b count=%b idx=%0d want 1/0111/5", seen, count, phase_idx); end
        clr = 1; clk_step(); clr = 0;
        checks++; if (count !== 4'b0000) begin errors++; $display("FAIL clr_idle got %b want 0000", count); end

        start = 1; steps = 2; dir = 0; clk_step(); start = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin clk_step(); if (done) seen = 1; end
        checks++; if (!seen || count !== 4'b1100) begin errors++; $display("FAIL b2b_first seen=%b count=%b want 1/1100", seen, count); end
        start = 1; steps = 3; dir = 1; clk_step(); start = 0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b want 1", busy); end
        seen = 0; n = 0;
        for (int k = 0; k < 20 && !seen; k++) begin clk_step(); n++; if (done) seen = 1; end
        checks++; if (!seen || n != 3 || count !== 4'b0001 || phase_idx !== 3'd7) begin errors++; $display("FAIL b2b_second seen=%b edges=%0d count=%b idx=%0d want 1/3/0001/7", seen, n, count, phase_idx); end
    endtask

    task automatic test_random();
        logic [7:0] ep;
        int bad;
        idle_inputs();
        bad = 0;
        for (int k = 0; k < 500; k++) begin
            start = ($urandom_range(0, 3) == 0);
            steps = CW'($urandom_range(0, 12));
            dir   = $urandom_range(0, 1) == 1;
            hold  = ($urandom_range(0, 4) == 0);
            abort = ($urandom_range(0, 30) == 0);
            clr   = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 99) == 0);
            clk_step();
            ep = 8'h01 << m_pos;
            checks++; if (count !== code_of(m_pos)) begin errors++; bad++; $display("FAIL rnd_count cyc=%0d got %b want %b", k, count, code_of(m_pos)); end
            checks++; if (phase_idx !== 3'(m_pos) || phase !== ep) begin errors++; bad++; $display("FAIL rnd_phase cyc=%0d idx=%0d phase=%b want %0d/%b", k, phase_idx, phase, m_pos, ep); end
            checks++; if (busy !== m_busy) begin errors++; bad++; $display("FAIL rnd_busy cyc=%0d got %b want %b", k, busy, m_busy); end
            checks++; if (done !== m_done) begin errors++; bad++; $display("FAIL rnd_done cyc=%0d got %b want %b", k, done, m_done); end
            if (bad > 20) break;
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_fwd3();
        test_wrap_rev();
        test_hold();
        test_abort();
        test_edge_cmds();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
